vga_timing_gen: RTL and testbench

VGA raster timing generator; the initiator side of the pixel-coordinate/colour interface consumed by the image-memory block.
- Scans a 640x480@60 Hz frame.
- Drives im_pixel_x/im_pixel_y to the image-memory block and samples its combinational im_rgb reply one pixel tick later.
- Drives the VGA connector with sync pulses time-aligned to that sampled colour, blanking colour outside the visible area.
- Sits in the top level between the system clock and the board VGA pins.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_pix_tick.sv | 27 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing, derived sync window bounds and the RGB field layout
// shared by the VGA raster generator.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int RGB_W = 12;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF      = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int R_MSB = 11;
  localparam int R_LSB = 8;
  localparam int G_MSB = 7;
  localparam int G_LSB = 4;
  localparam int B_MSB = 3;
  localparam int B_LSB = 0;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable: one-cycle tick every PIX_DIV system clocks.
module vga_pix_tick #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: presents pixel coordinates to image memory and drives the
// connector one pixel tick later with sync, display-enable and colour aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter int   PIX_DIV   = 4,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RGB_W-1:0]  im_rgb,
  output logic [CNT_W-1:0]  im_pixel_x,
  output logic [CNT_W-1:0]  im_pixel_y,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic tick;
  cnt_t h_cnt_p0;
  cnt_t v_cnt_p0;
  logic h_last;
  logic v_last;
  logic de_p0;
  logic hs_act_p0;
  logic vs_act_p0;
  logic vld_p1;
  logic hs_p1;
  logic vs_p1;
  rgb_t rgb_p1;
  logic fs_p1;

  vga_pix_tick #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Stage p0: raster counters, presented straight to the image memory
  assign h_last = (h_cnt_p0 == cnt_t'(H_TOTAL - 1));
  assign v_last = (v_cnt_p0 == cnt_t'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + 1'b1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
    end
  end

  assign im_pixel_x = h_cnt_p0;
  assign im_pixel_y = v_cnt_p0;

  assign de_p0     = (h_cnt_p0 < cnt_t'(H_VISIBLE)) && (v_cnt_p0 < cnt_t'(V_VISIBLE));
  assign hs_act_p0 = in_window(h_cnt_p0, cnt_t'(HS_START), cnt_t'(HS_END));
  assign vs_act_p0 = in_window(v_cnt_p0, cnt_t'(VS_START), cnt_t'(VS_END));

  // Stage p1: pin register; sync, enable and colour all sampled from one counter pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      hs_p1  <= ~SYNC_POL;
      vs_p1  <= ~SYNC_POL;
      rgb_p1 <= '0;
      fs_p1  <= 1'b0;
    end else begin
      fs_p1 <= tick && h_last && v_last;
      if (tick) begin
        vld_p1 <= de_p0;
        hs_p1  <= hs_act_p0 ? SYNC_POL : ~SYNC_POL;
        vs_p1  <= vs_act_p0 ? SYNC_POL : ~SYNC_POL;
        rgb_p1 <= de_p0 ? im_rgb : '0;
      end
    end
  end

  assign vga_de      = vld_p1;
  assign vga_hsync   = hs_p1;
  assign vga_vsync   = vs_p1;
  assign vga_r       = rgb_p1[R_MSB:R_LSB];
  assign vga_g       = rgb_p1[G_MSB:G_LSB];
  assign vga_b       = rgb_p1[B_MSB:B_LSB];
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 line timing at PIX_DIV=1, plus a shrunken raster at
// PIX_DIV=4 with active-high syncs for whole-frame and wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic force_white;
  logic [11:0] junk_b;

  logic [11:0] rgb_a, rgb_b;
  logic [9:0]  xa, ya, xb, yb;
  logic        hs_a, vs_a, de_a, fs_a;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [9:0] x, input logic [9:0] y);
    return {x[3:0], y[3:0], x[7:4]};
  endfunction

  assign rgb_a = force_white ? 12'hFFF : pat(xa, ya);
  assign rgb_b = pat(xb, yb) ^ junk_b;

  vga_timing_gen #(
    .PIX_DIV (1)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .im_rgb      (rgb_a),
    .im_pixel_x  (xa),
    .im_pixel_y  (ya),
    .vga_hsync   (hs_a),
    .vga_vsync   (vs_a),
    .vga_r       (r_a),
    .vga_g       (g_a),
    .vga_b       (b_a),
    .vga_de      (de_a),
    .frame_start (fs_a)
  );

  // 32x17 raster: sync h in [20,25], v in [12,13]
  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_VISIBLE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .PIX_DIV   (4),
    .SYNC_POL  (1'b1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .im_rgb      (rgb_b),
    .im_pixel_x  (xb),
    .im_pixel_y  (yb),
    .vga_hsync   (hs_b),
    .vga_vsync   (vs_b),
    .vga_r       (r_b),
    .vga_g       (g_b),
    .vga_b       (b_b),
    .vga_de      (de_b),
    .frame_start (fs_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int mx, my, c;
    int first_fall, rise, second_fall;
    int fs1, fs2, fs_cnt, vs_hi, hs_hi, ychg;
    logic e_de, e_hs, prev_hs;
    logic [11:0] e_rgb;
    logic [9:0] lx, ly;

    force_white = 1'b0;
    junk_b = 12'h000;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) step();

    check("rst_hs_a",  32'(hs_a), 32'd1);
    check("rst_vs_a",  32'(vs_a), 32'd1);
    check("rst_rgb_a", 32'({r_a, g_a, b_a}), 32'h0);
    check("rst_de_a",  32'(de_a), 32'd0);
    check("rst_x_a",   32'(xa), 32'd0);
    check("rst_y_a",   32'(ya), 32'd0);
    check("rst_fs_a",  32'(fs_a), 32'd0);
    check("rst_hs_b",  32'(hs_b), 32'd0);
    check("rst_vs_b",  32'(vs_b), 32'd0);
    check("rst_de_b",  32'(de_b), 32'd0);

    rst = 1'b1;
    mx = 0; my = 0;
    first_fall = 0; rise = 0; second_fall = 0;
    prev_hs = hs_a;
    for (int n = 1; n <= 2300; n++) begin
      force_white = ((n >= 630) && (n < 660)) || ((n >= 1000) && (n < 1004));
      e_de  = (mx < 640) && (my < 480);
      e_hs  = !((mx >= 656) && (mx <= 751));
      e_rgb = e_de ? (force_white ? 12'hFFF : pat(10'(mx), 10'(my))) : 12'h000;
      step();
      mx++;
      if (mx == 800) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end
      if (prev_hs && !hs_a) begin
        if (first_fall == 0) first_fall = n;
        else if (second_fall == 0) second_fall = n;
      end
      if (!prev_hs && hs_a && rise == 0) rise = n;
      prev_hs = hs_a;
      check("line_x_a",   32'(xa), 32'(mx));
      check("line_y_a",   32'(ya), 32'(my));
      check("line_hs_a",  32'(hs_a), 32'(e_hs));
      check("line_de_a",  32'(de_a), 32'(e_de));
      check("line_rgb_a", 32'({r_a, g_a, b_a}), 32'(e_rgb));
      check("line_vs_a",  32'(vs_a), 32'd1);
      check("line_fs_a",  32'(fs_a), 32'd0);
    end
    force_white = 1'b0;
    check("hs_first_fall", 32'(first_fall), 32'd657);
    check("hs_low_width",  32'(rise - first_fall), 32'd96);
    check("hs_period",     32'(second_fall - first_fall), 32'd800);
    check("pre_rst_x_a",   32'(xa), 32'd700);
    check("pre_rst_hs_a",  32'(hs_a), 32'd0);

    rst = 1'b0;
    #1;
    check("midrst_hs_a",  32'(hs_a), 32'd1);
    check("midrst_vs_a",  32'(vs_a), 32'd1);
    check("midrst_x_a",   32'(xa), 32'd0);
    check("midrst_y_a",   32'(ya), 32'd0);
    check("midrst_de_a",  32'(de_a), 32'd0);
    check("midrst_rgb_a", 32'({r_a, g_a, b_a}), 32'h0);
    check("midrst_hs_b",  32'(hs_b), 32'd0);
    check("midrst_x_b",   32'(xb), 32'd0);
    repeat (2) step();
    check("hold_rst_x_a", 32'(xa), 32'd0);

    rst = 1'b1;
    c = 0;
    step(); c++;
    check("rel_tick_x_a", 32'(xa), 32'd1);
    check("rel_x_b_c1",   32'(xb), 32'd0);
    step(); c++;
    step(); c++;
    check("rel_x_b_c3",   32'(xb), 32'd0);
    step(); c++;
    check("rel_x_b_c4",   32'(xb), 32'd1);
    check("rel_y_b_c4",   32'(yb), 32'd0);

    fs1 = 0; fs2 = 0; fs_cnt = 0; vs_hi = 0; hs_hi = 0; ychg = 0;
    while ((c < 4800) && (fs2 == 0)) begin
      junk_b = (((c + 1) % 4) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      lx = xb;
      ly = yb;
      step(); c++;
      if ((c % 4) == 0) begin
        e_de = (lx < 10'd16) && (ly < 10'd10);
        check("frm_de_b",  32'(de_b), 32'(e_de));
        check("frm_rgb_b", 32'({r_b, g_b, b_b}), e_de ? 32'(pat(lx, ly)) : 32'h0);
      end else begin
        check("frm_x_hold_b", 32'(xb), 32'(lx));
      end
      if (fs_b) begin
        fs_cnt++;
        if (fs1 == 0) fs1 = c;
        else if (fs2 == 0) fs2 = c;
      end
      if ((fs1 != 0) && (c > fs1) && (yb != ly)) begin
        ychg++;
        check("frm_y_seq_b", 32'(yb), (ly == 10'd16) ? 32'd0 : 32'(ly) + 32'd1);
      end
      if ((fs1 != 0) && (fs2 == 0)) begin
        if (vs_b) vs_hi++;
        if (hs_b) hs_hi++;
      end
      if ((fs1 != 0) && (c == fs1)) begin
        check("wrap_x_b",  32'(xb), 32'd0);
        check("wrap_y_b",  32'(yb), 32'd0);
        check("wrap_de_b", 32'(de_b), 32'd0);
      end
      if ((fs1 != 0) && (c == fs1 + 1)) check("wrap_fs_1clk", 32'(fs_b), 32'd0);
      if ((fs1 != 0) && (c == fs1 + 3)) check("wrap_de_late", 32'(de_b), 32'd0);
      if ((fs1 != 0) && (c == fs1 + 4)) check("wrap_de_on",   32'(de_b), 32'd1);
    end
    junk_b = 12'h000;
    check("fs_first_at",    32'(fs1), 32'd2176);
    check("fs_period",      32'(fs2 - fs1), 32'd2176);
    check("fs_pulse_count", 32'(fs_cnt), 32'd2);
    check("vs_active_clks", 32'(vs_hi), 32'd256);
    check("hs_active_clks", 32'(hs_hi), 32'd408);
    check("y_change_count", 32'(ychg), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
